// File: rtl/rhythm_recorder.sv
// Captures debounced button presses into a beat-indexed rhythm map, one slot per beat_tick.
// Bit 0 of recorded_map holds the first beat once MAP_LEN beats have been recorded.
module rhythm_recorder #(
   parameter int unsigned MAP_LEN         = 191,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned CNT_W           = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               beat_tick,
   input  logic               start,
   input  logic               button,
   output logic [MAP_LEN-1:0] recorded_map,
   output logic               map_valid,
   output logic               recording,
   output logic [CNT_W-1:0]   beat_index,
   output logic [CNT_W-1:0]   note_count,
   output logic               note_seen
);

   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned N_KEYS = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECORD,
      S_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [N_KEYS-1:0]       r_sync1;
   logic [N_KEYS-1:0]       r_sync2;
   logic [N_KEYS-1:0]       r_level;
   logic [DB_W-1:0]         r_db_cnt [N_KEYS];
   logic [N_KEYS-1:0]       w_fall;
   logic                    w_press_evt;
   logic                    w_start_evt;
   logic                    w_clear;
   logic                    w_shift;
   logic                    w_note_in;
   logic                    r_note_latch;

   // Index 0 = note key, index 1 = start key; both active-low, released level is 1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_level <= '1;
         for (int i = 0; i < int'(N_KEYS); i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1 <= {start, button};
         r_sync2 <= r_sync1;
         for (int i = 0; i < int'(N_KEYS); i++) begin
            if (r_sync2[i] == r_level[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               r_level[i]  <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Event fires in the cycle whose closing edge accepts a 1->0 level change
   always_comb begin
      w_fall = '0;
      for (int i = 0; i < int'(N_KEYS); i++) begin
         w_fall[i] = (r_sync2[i] != r_level[i]) && !r_sync2[i] &&
                     (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
      end
   end

   assign w_press_evt = w_fall[0];
   assign w_start_evt = w_fall[1];
   assign w_note_in   = r_note_latch | w_press_evt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Abort via start takes priority over a coincident beat shift
   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_evt) begin
               w_state_nxt = S_RECORD;
               w_clear     = 1'b1;
            end
         end
         S_RECORD: begin
            if (w_start_evt) begin
               w_state_nxt = S_IDLE;
            end else if (beat_tick) begin
               w_shift = 1'b1;
               if (beat_index == CNT_W'(MAP_LEN - 1)) w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (w_start_evt) begin
               w_state_nxt = S_RECORD;
               w_clear     = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         recorded_map <= '0;
         map_valid    <= 1'b0;
         recording    <= 1'b0;
         beat_index   <= '0;
         note_count   <= '0;
         r_note_latch <= 1'b0;
      end else begin
         recording <= (w_state_nxt == S_RECORD);
         if (w_clear) begin
            recorded_map <= '0;
            map_valid    <= 1'b0;
            beat_index   <= '0;
            note_count   <= '0;
            r_note_latch <= 1'b0;
         end else if (r_state == S_RECORD) begin
            if (w_start_evt) begin
               r_note_latch <= 1'b0;
            end else if (w_shift) begin
               recorded_map <= {w_note_in, recorded_map[MAP_LEN-1:1]};
               beat_index   <= beat_index + CNT_W'(1);
               r_note_latch <= 1'b0;
               if (w_note_in && (note_count != {CNT_W{1'b1}}))
                  note_count <= note_count + CNT_W'(1);
               if (w_state_nxt == S_DONE) map_valid <= 1'b1;
            end else if (w_press_evt) begin
               r_note_latch <= 1'b1;
            end
         end
      end
   end

   assign note_seen = r_note_latch;

endmodule

// File: tb/tb_rhythm_recorder.sv
// Scoreboard bench for rhythm_recorder: expected output snapshots are queued by the stimulus
// and popped by a monitor whenever the observed outputs change.
module tb_rhythm_recorder;

   localparam int unsigned MAP_LEN = 8;
   localparam int unsigned DEB     = 4;
   localparam int unsigned CNT_W   = 4;

   typedef struct packed {
      logic [7:0] map;
      logic       valid;
      logic       rec;
      logic [3:0] bidx;
      logic [3:0] ncnt;
   } snap_t;

   logic               clk;
   logic               rst;
   logic               beat_tick;
   logic               start;
   logic               button;
   logic [MAP_LEN-1:0] recorded_map;
   logic               map_valid;
   logic               recording;
   logic [CNT_W-1:0]   beat_index;
   logic [CNT_W-1:0]   note_count;
   logic               note_seen;

   snap_t exp_q[$];
   string name_q[$];
   int    tests;
   int    fails;
   snap_t prev;

   rhythm_recorder #(.MAP_LEN(MAP_LEN), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .beat_tick(beat_tick), .start(start), .button(button),
      .recorded_map(recorded_map), .map_valid(map_valid), .recording(recording),
      .beat_index(beat_index), .note_count(note_count), .note_seen(note_seen)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: every change of the observable outputs must match the next queued snapshot
   initial begin
      snap_t cur;
      snap_t e;
      string n;
      prev = '1;
      forever begin
         @(negedge clk);
         cur.map   = recorded_map;
         cur.valid = map_valid;
         cur.rec   = recording;
         cur.bidx  = beat_index;
         cur.ncnt  = note_count;
         if (cur != prev) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_change got map=%h valid=%0b rec=%0b bidx=%0d ncnt=%0d, required no change",
                        cur.map, cur.valid, cur.rec, cur.bidx, cur.ncnt);
            end else begin
               e = exp_q.pop_front();
               n = name_q.pop_front();
               if (cur !== e) begin
                  fails++;
                  $display("FAIL %s got map=%h valid=%0b rec=%0b bidx=%0d ncnt=%0d, required map=%h valid=%0b rec=%0b bidx=%0d ncnt=%0d",
                           n, cur.map, cur.valid, cur.rec, cur.bidx, cur.ncnt,
                           e.map, e.valid, e.rec, e.bidx, e.ncnt);
               end
            end
            prev = cur;
         end
      end
   end

   task automatic push(input string n, input logic [7:0] m, input logic v, input logic r,
                       input logic [3:0] b, input logic [3:0] c);
      snap_t s;
      s.map = m; s.valid = v; s.rec = r; s.bidx = b; s.ncnt = c;
      exp_q.push_back(s);
      name_q.push_back(n);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press();
      button = 1'b0;
      cyc(8);
      button = 1'b1;
      cyc(8);
   endtask

   task automatic start_pulse();
      start = 1'b0;
      cyc(8);
      start = 1'b1;
      cyc(8);
   endtask

   task automatic tick();
      beat_tick = 1'b1;
      cyc(1);
      beat_tick = 1'b0;
      cyc(2);
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] em;
      int         nc;
      tests = 0;
      fails = 0;
      rst = 1'b1; start = 1'b1; button = 1'b1; beat_tick = 1'b0;
      push("reset_state", 8'h00, 1'b0, 1'b0, 4'd0, 4'd0);
      #1 rst = 1'b0;
      cyc(3);
      rst = 1'b1;
      cyc(4);

      // Full recording: notes in beats 0,2,3,7
      push("rec_start", 8'h00, 1'b0, 1'b1, 4'd0, 4'd0);
      start_pulse();
      pat = 8'b1000_1101;
      em  = 8'h00;
      nc  = 0;
      for (int i = 0; i < 8; i++) begin
         if (pat[i]) press();
         em = {pat[i], em[7:1]};
         nc = nc + int'(pat[i]);
         if (i == 7) push("rec_final", 8'h8D, 1'b1, 1'b0, 4'd8, 4'd4);
         else        push("rec_beat", em, 1'b0, 1'b1, 4'(i + 1), 4'(nc));
         tick();
      end

      // DONE ignores ticks and presses
      tick(); tick(); press(); tick();

      push("rearm_done", 8'h00, 1'b0, 1'b1, 4'd0, 4'd0);
      start_pulse();

      // Bouncing key followed by a steady press: a single note
      for (int i = 0; i < 10; i++) begin
         button = ~button;
         cyc(2);
      end
      press();
      push("bounce_beat", 8'h80, 1'b0, 1'b1, 4'd1, 4'd1);
      tick();

      press(); press(); press();
      push("multi_press_beat", 8'hC0, 1'b0, 1'b1, 4'd2, 4'd2);
      tick();

      // Press event lands on the same edge as the beat tick
      button = 1'b0;
      cyc(5);
      beat_tick = 1'b1;
      push("coincide_beat", 8'hE0, 1'b0, 1'b1, 4'd3, 4'd3);
      cyc(1);
      beat_tick = 1'b0;
      cyc(3);
      button = 1'b1;
      cyc(8);
      push("after_coincide", 8'h70, 1'b0, 1'b1, 4'd4, 4'd3);
      tick();
      push("beat4", 8'h38, 1'b0, 1'b1, 4'd5, 4'd3);
      tick();

      push("abort_beat5", 8'h38, 1'b0, 1'b0, 4'd5, 4'd3);
      start_pulse();
      tick(); press(); tick();

      push("restart", 8'h00, 1'b0, 1'b1, 4'd0, 4'd0);
      start_pulse();
      press();
      push("restart_b0", 8'h80, 1'b0, 1'b1, 4'd1, 4'd1);
      tick();
      push("restart_b1", 8'h40, 1'b0, 1'b1, 4'd2, 4'd1);
      tick();

      // Abort coinciding with a tick: no shift
      start = 1'b0;
      cyc(5);
      beat_tick = 1'b1;
      push("abort_with_tick", 8'h40, 1'b0, 1'b0, 4'd2, 4'd1);
      cyc(1);
      beat_tick = 1'b0;
      cyc(3);
      start = 1'b1;
      cyc(8);
      tick();

      // Async reset mid-recording
      push("pre_reset_start", 8'h00, 1'b0, 1'b1, 4'd0, 4'd0);
      start_pulse();
      press();
      push("pre_reset_b0", 8'h80, 1'b0, 1'b1, 4'd1, 4'd1);
      tick();
      push("pre_reset_b1", 8'h40, 1'b0, 1'b1, 4'd2, 4'd1);
      tick();
      press();
      push("pre_reset_b2", 8'hA0, 1'b0, 1'b1, 4'd3, 4'd2);
      tick();
      push("async_reset", 8'h00, 1'b0, 1'b0, 4'd0, 4'd0);
      #3 rst = 1'b0;
      cyc(2);
      rst = 1'b1;
      cyc(4);
      tick(); press(); tick();

      cyc(5);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_expectations got %0d unobserved, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
